// File: rtl/medidor_periodo.sv
`timescale 1ns/1ps
// medidor_periodo: measures the period and high time of an asynchronous
// periodic input in clk cycles.
//
// Ports
//   clk       : system clock. All state updates on its rising edge.
//   reset     : synchronous, active-high reset.
//   sig_in    : asynchronous signal to measure.
//   period    : clk cycles between the last two accepted rising edges.
//   high_time : clk cycles from the last accepted rise to the following fall.
//   valid     : one-cycle pulse when period has just been updated.
//   timeout   : level. High while no rise has been seen for 2^WIDTH-1 cycles.
//
// Latency: a sig_in change driven just after clk edge k is captured by s1 at
// edge k+1. The matching period/valid or high_time update is visible after
// edge k+3.
module medidor_periodo #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [WIDTH-1:0] r_cnt;
  logic             r_armed;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high;
  logic             r_valid;
  logic             r_timeout;

  logic             w_rise;
  logic             w_fall;
  logic [WIDTH-1:0] w_cnt_next;

  // Edge detection on the synchronized signal against its one-cycle history.
  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  // Saturating increment. The counter never wraps, so a stalled input is
  // reported as a timeout instead of a bogus short period.
  assign w_cnt_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + WIDTH'(1);

  // Synchronizer, cycle counter and measurement registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_cnt     <= '0;
      r_armed   <= 1'b0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_s1    <= sig_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;
      if (w_rise) begin
        // A rise always restarts the count, re-arms and clears timeout. It
        // reports a period only if the previous rise was already accepted.
        r_cnt     <= WIDTH'(1);
        r_armed   <= 1'b1;
        r_timeout <= 1'b0;
        if (r_armed && !r_timeout) begin
          r_period <= r_cnt;
          r_valid  <= 1'b1;
        end
      end else begin
        r_cnt <= w_cnt_next;
        // The stale previous rise cannot delimit a period, so disarm.
        if (w_cnt_next == CNT_MAX) begin
          r_timeout <= 1'b1;
          r_armed   <= 1'b0;
        end
        if (w_fall && r_armed && !r_timeout) begin
          r_high <= r_cnt;
        end
      end
    end
  end

  assign period    = r_period;
  assign high_time = r_high;
  assign valid     = r_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_medidor_periodo.sv
`timescale 1ns/1ps
// Bench for medidor_periodo. It uses a WIDTH=16 instance for the measurement
// scenarios and a WIDTH=4 instance for the timeout scenario. Expected
// period/high_time/arrival cycle are computed from the driven waveform and
// queued, then popped when the DUT pulses valid.
module tb_medidor_periodo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        sig16 = 1'b0;
  logic        sig4  = 1'b0;
  logic [15:0] period16;
  logic [15:0] high16;
  logic        valid16;
  logic        timeout16;
  logic [3:0]  period4;
  logic [3:0]  high4;
  logic        valid4;
  logic        timeout4;

  medidor_periodo #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .sig_in(sig16),
    .period(period16), .high_time(high16), .valid(valid16), .timeout(timeout16)
  );

  medidor_periodo #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .sig_in(sig4),
    .period(period4), .high_time(high4), .valid(valid4), .timeout(timeout4)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] period;
    logic [15:0] high;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          v16_cnt = 0;
  int          v4_cnt = 0;
  logic        prev_valid16 = 1'b0;

  // Waveform model state for the WIDTH=16 instance.
  logic        m_prev = 1'b0;
  bit          m_armed = 1'b0;
  int unsigned m_last_rise = 0;
  logic [15:0] m_high = '0;

  // Scoreboard consumer: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (valid16) begin
      v16_cnt++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL valid16_unexpected: valid at cycle %0d, required no pulse", cyc);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (period16 !== e.period) begin
          n_bad++;
          $display("FAIL period16: got %0d, expected %0d (cycle %0d)", period16, e.period, cyc);
        end
        n_cmp++;
        if (high16 !== e.high) begin
          n_bad++;
          $display("FAIL high16: got %0d, expected %0d (cycle %0d)", high16, e.high, cyc);
        end
        n_cmp++;
        if (cyc !== e.due) begin
          n_bad++;
          $display("FAIL valid16_latency: valid at cycle %0d, expected %0d", cyc, e.due);
        end
      end
      n_cmp++;
      if (prev_valid16 !== 1'b0) begin
        n_bad++;
        $display("FAIL valid16_back_to_back: previous valid %0d, expected 0", prev_valid16);
      end
    end
    prev_valid16 <= valid16;
    if (valid4) v4_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  // One clk cycle on the WIDTH=16 input. Rises and falls update the model.
  task automatic step16(input logic b);
    @(posedge clk); #1;
    if (b && !m_prev) begin
      if (m_armed)
        sb.push_back('{period: 16'(cyc - m_last_rise), high: m_high, due: cyc + 3});
      m_armed     = 1'b1;
      m_last_rise = cyc;
    end
    if (!b && m_prev) m_high = 16'(cyc - m_last_rise);
    m_prev = b;
    sig16  = b;
  endtask

  task automatic step4(input logic b);
    @(posedge clk); #1;
    sig4 = b;
  endtask

  task automatic drive_wave(input int p, input int h, input int n);
    repeat (n) begin
      repeat (h) step16(1'b1);
      repeat (p - h) step16(1'b0);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_armed = 1'b0;
    m_prev  = 1'b0;
    m_high  = '0;
  endtask

  task automatic check_steady(input string tag, input logic [15:0] ep, input logic [15:0] eh);
    repeat (5) step16(1'b0);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_pending: %0d valid pulses missing, expected 0", tag, sb.size());
    end
    n_cmp++;
    if (period16 !== ep) begin
      n_bad++;
      $display("FAIL %s_period: got %0d, expected %0d", tag, period16, ep);
    end
    n_cmp++;
    if (high16 !== eh) begin
      n_bad++;
      $display("FAIL %s_high: got %0d, expected %0d", tag, high16, eh);
    end
    n_cmp++;
    if (timeout16 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d, expected 0", tag, timeout16);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sig16 = 1'b0;
    sig4  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({period16, high16, valid16, timeout16} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset16: got p=%0d h=%0d v=%0d t=%0d, expected all 0",
               period16, high16, valid16, timeout16);
    end
    n_cmp++;
    if ({period4, high4, valid4, timeout4} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset4: got p=%0d h=%0d v=%0d t=%0d, expected all 0",
               period4, high4, valid4, timeout4);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_clk_div2();
    drive_wave(2, 1, 12);
    check_steady("div2", 16'd2, 16'd1);
  endtask

  task automatic test_period10();
    drive_wave(10, 3, 5);
    check_steady("p10", 16'd10, 16'd3);
  endtask

  task automatic test_reset_mid();
    int v0;
    drive_wave(10, 3, 3);
    // A rise is in the synchronizer when reset hits; it must be discarded.
    step16(1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({period16, high16, valid16, timeout16} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got p=%0d h=%0d v=%0d t=%0d, expected all 0",
               period16, high16, valid16, timeout16);
    end
    reset = 1'b0;
    sig16 = 1'b0;
    model_reset();
    v0 = v16_cnt;
    drive_wave(10, 3, 1);
    n_cmp++;
    if (v16_cnt !== v0) begin
      n_bad++;
      $display("FAIL reset_mid_first_rise: got %0d valid pulses, expected 0", v16_cnt - v0);
    end
    drive_wave(10, 3, 3);
    check_steady("reset_mid", 16'd10, 16'd3);
  endtask

  task automatic test_period_change();
    drive_wave(6, 2, 5);
    repeat (4) step16(1'b0);
    drive_wave(14, 7, 5);
    check_steady("p6_to_p14", 16'd14, 16'd7);
  endtask

  task automatic test_timeout();
    int v0;
    n_cmp++;
    if (timeout4 !== 1'b1) begin
      n_bad++;
      $display("FAIL to_idle: timeout4 got %0d, expected 1", timeout4);
    end
    v0 = v4_cnt;
    // The first rise clears timeout; the next two each give period 4.
    repeat (3) begin step4(1'b1); step4(1'b1); step4(1'b0); step4(1'b0); end
    step4(1'b1);
    for (int i = 1; i <= 17; i++) begin
      step4(1'b1);
      if (i == 16) begin
        n_cmp++;
        if (timeout4 !== 1'b0) begin
          n_bad++;
          $display("FAIL to_early: timeout4 got %0d, expected 0", timeout4);
        end
      end
      if (i == 17) begin
        n_cmp++;
        if (timeout4 !== 1'b1 || period4 !== 4'd4) begin
          n_bad++;
          $display("FAIL to_set: got t=%0d p=%0d, expected t=1 p=4", timeout4, period4);
        end
      end
    end
    repeat (5) step4(1'b1);
    repeat (4) step4(1'b0);
    n_cmp++;
    if (timeout4 !== 1'b1 || period4 !== 4'd4 || high4 !== 4'd2) begin
      n_bad++;
      $display("FAIL to_hold: got t=%0d p=%0d h=%0d, expected t=1 p=4 h=2",
               timeout4, period4, high4);
    end
    n_cmp++;
    if (v4_cnt - v0 !== 3) begin
      n_bad++;
      $display("FAIL to_valid_count: got %0d pulses, expected 3", v4_cnt - v0);
    end
    // Resume with period 5: the re-arming rise gives no valid.
    step4(1'b1); step4(1'b1); step4(1'b0);
    n_cmp++;
    if (timeout4 !== 1'b1) begin
      n_bad++;
      $display("FAIL to_clear_early: timeout4 got %0d, expected 1", timeout4);
    end
    step4(1'b0);
    n_cmp++;
    if (timeout4 !== 1'b0) begin
      n_bad++;
      $display("FAIL to_clear: timeout4 got %0d, expected 0", timeout4);
    end
    step4(1'b0); step4(1'b1); step4(1'b1); step4(1'b0);
    n_cmp++;
    if (v4_cnt - v0 !== 3) begin
      n_bad++;
      $display("FAIL to_rearm_no_valid: got %0d pulses, expected 3", v4_cnt - v0);
    end
    step4(1'b0);
    n_cmp++;
    if (valid4 !== 1'b1 || period4 !== 4'd5 || high4 !== 4'd2) begin
      n_bad++;
      $display("FAIL to_resume: got v=%0d p=%0d h=%0d, expected v=1 p=5 h=2",
               valid4, period4, high4);
    end
    step4(1'b0);
    n_cmp++;
    if (valid4 !== 1'b0 || v4_cnt - v0 !== 4) begin
      n_bad++;
      $display("FAIL to_resume_pulse: got v=%0d count=%0d, expected v=0 count=4",
               valid4, v4_cnt - v0);
    end
  endtask

  initial begin
    test_reset();
    test_clk_div2();
    test_period10();
    test_reset_mid();
    test_period_change();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
